// File: rtl/vga_pkg.sv
// vga_pkg: row geometry and shared types for the VGA row interface
package vga_pkg;
   localparam int WORD_W        = 16;
   localparam int WORDS_PER_ROW = 30;
   localparam int ROW_W         = WORD_W * WORDS_PER_ROW;
   localparam int ROWS          = 480;
   typedef enum logic {FILL, FULL} row_state_t;
   typedef logic [9:0] row_idx_t;
endpackage

// File: rtl/vga_row_packer.sv
// vga_row_packer: packs 16-bit pixel words into a 480-bit row held until acknowledged
module vga_row_packer #(
   parameter  int WORD_W        = vga_pkg::WORD_W,
   parameter  int WORDS_PER_ROW = vga_pkg::WORDS_PER_ROW,
   parameter  int ROWS          = vga_pkg::ROWS,
   localparam int ROW_W         = WORD_W * WORDS_PER_ROW
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              sof,
   input  logic              in_valid,
   input  logic [WORD_W-1:0] in_word,
   output logic              in_ready,
   input  logic              row_ack,
   output logic [ROW_W-1:0]  StorageBytes,
   output logic              finished,
   output logic [9:0]        row_index,
   output logic              frame_done
);
   import vga_pkg::*;
   localparam int IDX_W = $clog2(WORDS_PER_ROW);
   row_state_t       state, state_n;
   logic [IDX_W-1:0] word_idx, widx;
   logic             accept, last_word, ack;
   assign in_ready = state == FILL;
   assign finished = state == FULL;
   // sof restarts the row, so a word arriving with it lands in slice 0
   always_comb begin
      accept    = in_valid && in_ready;
      widx      = sof ? '0 : word_idx;
      last_word = widx == IDX_W'(WORDS_PER_ROW - 1);
      ack       = finished && row_ack && !sof;
      state_n   = (accept && last_word) ? FULL : (sof || ack) ? FILL : state;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FILL;
         word_idx     <= '0;
         row_index    <= '0;
         StorageBytes <= '0;
         frame_done   <= 1'b0;
      end else begin
         state      <= state_n;
         frame_done <= ack && row_index == row_idx_t'(ROWS - 1);
         if (accept) StorageBytes[int'(widx) * WORD_W +: WORD_W] <= in_word;
         if (accept) word_idx <= last_word ? '0 : widx + 1'b1;
         else if (sof) word_idx <= '0;
         if (sof) row_index <= '0;
         else if (ack) row_index <= (row_index == row_idx_t'(ROWS - 1)) ? '0 : row_index + 1'b1;
      end
   end
endmodule

// File: tb/tb_vga_row_packer.sv
// tb_vga_row_packer: directed checks of row packing, hold/ack, sof, frame wrap and reset
module tb_vga_row_packer;
   logic         clk = 1'b0;
   logic         rst, sof, in_valid, row_ack;
   logic [15:0]  in_word;
   logic         in_ready, finished, frame_done;
   logic [479:0] StorageBytes, exp_v;
   logic [9:0]   row_index;
   int           n_cmp = 0, n_bad = 0;

   vga_row_packer dut (
      .clk(clk), .rst(rst), .sof(sof), .in_valid(in_valid), .in_word(in_word),
      .in_ready(in_ready), .row_ack(row_ack), .StorageBytes(StorageBytes),
      .finished(finished), .row_index(row_index), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [479:0] got, input logic [479:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // words base+k, one per accepted handshake; gapped mode also pokes row_ack during FILL
   task automatic send_words(input int n, input logic [15:0] base, input bit gaps);
      int k = 0, budget = 0;
      bit acc;
      while (k < n && budget < 1000) begin
         in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
         row_ack  = gaps && !in_valid;
         in_word  = base + 16'(k);
         acc      = in_valid && in_ready;
         @(negedge clk);
         if (acc) k++;
         budget++;
      end
      in_valid = 1'b0;
      row_ack  = 1'b0;
      if (k < n) check("send_timeout", 480'(k), 480'(n));
   endtask

   task automatic pulse_ack();
      row_ack = 1'b1;
      @(negedge clk);
      row_ack = 1'b0;
   endtask

   initial begin
      int acks = 0, fd_cnt = 0, cyc = 0;
      logic [9:0] exp_r, prev_row;
      logic prev_full;
      rst = 1'b1; sof = 1'b0; in_valid = 1'b0; row_ack = 1'b0; in_word = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check("rst_finished", finished, 0);
      check("rst_ready", in_ready, 1);
      check("rst_row", row_index, 0);
      check("rst_storage", StorageBytes, 0);
      check("rst_fd", frame_done, 0);

      for (int i = 0; i < 30; i++) begin
         in_valid = 1'b1;
         in_word  = 16'(i);
         @(negedge clk);
         if (i == 28) check("fin_early", finished, 0);
      end
      for (int k = 0; k < 30; k++) exp_v[16*k +: 16] = 16'(k);
      check("row0_finished", finished, 1);
      check("row0_ready", in_ready, 0);
      check("row0_lsw", StorageBytes[15:0], 16'h0000);
      check("row0_msw", StorageBytes[479:464], 16'h001D);

      in_word = 16'hBEEF;
      repeat (10) @(negedge clk);
      check("bp_storage", StorageBytes, exp_v);
      check("bp_ready", in_ready, 0);
      check("bp_finished", finished, 1);
      row_ack = 1'b1;
      @(negedge clk);
      row_ack = 1'b0;
      check("ack_finished", finished, 0);
      check("ack_ready", in_ready, 1);
      check("ack_row", row_index, 1);
      @(negedge clk);
      in_valid = 1'b0;
      check("beef_word0", StorageBytes[15:0], 16'hBEEF);
      check("beef_rest", StorageBytes[479:16], exp_v[479:16]);
      send_words(29, 16'h0101, 1'b0);
      exp_v[15:0] = 16'hBEEF;
      for (int k = 1; k < 30; k++) exp_v[16*k +: 16] = 16'h0100 + 16'(k);
      check("row1_storage", StorageBytes, exp_v);
      check("row1_finished", finished, 1);
      check("row1_row", row_index, 1);

      pulse_ack();
      send_words(30, 16'h0000, 1'b1);
      for (int k = 0; k < 30; k++) exp_v[16*k +: 16] = 16'(k);
      check("gap_storage", StorageBytes, exp_v);
      check("gap_row", row_index, 2);
      check("gap_finished", finished, 1);

      pulse_ack();
      send_words(30, 16'h0300, 1'b0);
      pulse_ack();
      send_words(30, 16'h0400, 1'b0);
      pulse_ack();
      check("row5_row", row_index, 5);
      send_words(12, 16'h0500, 1'b0);
      sof = 1'b1; in_valid = 1'b1; in_word = 16'h1234;
      @(negedge clk);
      sof = 1'b0; in_valid = 1'b0;
      check("sof_row", row_index, 0);
      check("sof_finished", finished, 0);
      check("sof_word0", StorageBytes[15:0], 16'h1234);
      send_words(28, 16'h0601, 1'b0);
      check("sof_fin_early", finished, 0);
      send_words(1, 16'h061D, 1'b0);
      check("sof_finished_29", finished, 1);
      exp_v[15:0] = 16'h1234;
      for (int k = 1; k < 30; k++) exp_v[16*k +: 16] = 16'h0600 + 16'(k);
      check("sof_storage", StorageBytes, exp_v);
      check("sof_row_held", row_index, 0);

      exp_r = 10'd0; prev_full = finished; prev_row = row_index;
      row_ack = 1'b1; in_valid = 1'b1; in_word = 16'h7777;
      while (acks < 480 && cyc < 20000) begin
         @(negedge clk);
         cyc++;
         if (frame_done) begin
            fd_cnt++;
            check("fd_after_479", {prev_full, prev_row}, {1'b1, 10'd479});
         end
         if (prev_full) begin
            acks++;
            exp_r = (exp_r == 10'd479) ? 10'd0 : exp_r + 10'd1;
            check("wrap_step", row_index, exp_r);
         end
         prev_full = finished; prev_row = row_index;
      end
      row_ack = 1'b0; in_valid = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (frame_done) fd_cnt++;
      end
      check("wrap_acks", 480'(acks), 480);
      check("wrap_fd_count", 480'(fd_cnt), 1);
      check("wrap_row0", row_index, 0);

      send_words(30, 16'h0900, 1'b0);
      pulse_ack();
      send_words(30, 16'h0A00, 1'b0);
      check("hold_row", row_index, 1);
      check("hold_finished", finished, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst_finished", finished, 0);
      check("mrst_ready", in_ready, 1);
      check("mrst_row", row_index, 0);
      check("mrst_storage", StorageBytes, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
